// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and ASCII constants
// used by blocks that feed the UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int UART_DATA_W = 8;

    localparam logic [UART_DATA_W-1:0] CHAR_A  = 8'h41;
    localparam logic [UART_DATA_W-1:0] CHAR_B  = 8'h42;
    localparam logic [UART_DATA_W-1:0] CHAR_C  = 8'h43;
    localparam logic [UART_DATA_W-1:0] CHAR_D  = 8'h44;
    localparam logic [UART_DATA_W-1:0] CHAR_P  = 8'h50;
    localparam logic [UART_DATA_W-1:0] CHAR_LF = 8'h0A;
    localparam logic [UART_DATA_W-1:0] CHAR_CR = 8'h0D;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: scans requests starting just after the
// last granted index, wrapping modulo N, and returns the first hit.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand [N];

    // cand[gi] is the index examined at priority position gi (0 = highest)
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum      = {1'b0, last_idx} + (IW+1)'(gi + 1);
            assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
        end
    endgenerate

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin priority;
// latches the winner's byte, strobes start, and holds the byte until the frame ends.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      i_reset_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic                      i_uart_busy,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_start_uart,
    output logic [DATA_W-1:0]         o_uart_data,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t          state_reg;
    logic [IW-1:0]       rr_ptr_reg;
    logic [NUM_REQ-1:0]  grant_reg;
    logic                start_reg;
    logic                timeout_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [CW-1:0]       count_reg;
    logic [CW-1:0]       count_next;

    logic [DATA_W-1:0]   req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]  sel_grant;
    logic [IW-1:0]       sel_idx;
    logic                sel_any;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = i_req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req      (i_req),
        .last_idx (rr_ptr_reg),
        .grant    (sel_grant),
        .idx      (sel_idx),
        .any      (sel_any)
    );

    assign count_next = count_reg + CW'(1);

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= IW'(NUM_REQ - 1);
            grant_reg   <= '0;
            start_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            data_reg    <= '0;
            count_reg   <= '0;
        end else begin
            // grant, start and timeout are one-cycle pulses unless re-asserted below
            grant_reg   <= '0;
            start_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sel_any) begin
                        state_reg  <= START;
                        grant_reg  <= sel_grant;
                        start_reg  <= 1'b1;
                        data_reg   <= req_bytes[sel_idx];
                        rr_ptr_reg <= sel_idx;
                    end
                end
                START: begin
                    count_reg <= '0;
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_uart_busy) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        count_reg <= count_next;
                        // transmitter never acknowledged: drop the byte, no retry
                        if (count_next == CW'(BUSY_TIMEOUT)) begin
                            timeout_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!i_uart_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_grant      = grant_reg;
    assign o_start_uart = start_reg;
    assign o_uart_data  = data_reg;
    assign o_busy       = (state_reg != IDLE);
    assign o_timeout    = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants/bytes are queued at stimulus
// time and compared by a monitor on every start strobe; timing checks run inline.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [3:0]  i_req;
    logic [31:0] i_req_data;
    logic        i_uart_busy;
    logic [3:0]  o_grant;
    logic        o_start_uart;
    logic [7:0]  o_uart_data;
    logic        o_busy;
    logic        o_timeout;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   busy_delay   = 2;
    int   busy_len     = 5;
    bit   tx_mute      = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .DATA_W       (8),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_req        (i_req),
        .i_req_data   (i_req_data),
        .i_uart_busy  (i_uart_busy),
        .o_grant      (o_grant),
        .o_start_uart (o_start_uart),
        .o_uart_data  (o_uart_data),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", tag, obs, $time);
        end
    endtask

    // Scoreboard monitor: every start strobe must match the next queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_start_uart === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("start_unexpected", 32'(o_start_uart), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("sb_grant", 32'(o_grant), 32'(mon_e.grant));
                    check_eq("sb_data", 32'(o_uart_data), 32'(mon_e.data));
                end
            end else if (o_grant !== 4'b0000 && i_reset_n === 1'b1) begin
                check_eq("grant_without_start", 32'(o_grant), 32'h0);
            end
        end
    end

    // Transmitter model: raises busy busy_delay cycles after start, for busy_len cycles
    initial begin
        i_uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (o_start_uart === 1'b1 && !tx_mute) begin
                repeat (busy_delay) @(posedge clk);
                #2;
                i_uart_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #2;
                i_uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time expired, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_req     = 4'b0000;
        i_reset_n = 1'b0;
        repeat (2) tick();
        i_reset_n = 1'b1;
    endtask

    task automatic wait_start(input string tag);
        for (int c = 0; c < 100; c++) begin
            tick();
            if (o_start_uart === 1'b1) return;
        end
        check_eq(tag, 32'(o_start_uart), 32'h1);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 300; c++) begin
            tick();
            if (o_busy === 1'b0) begin
                check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
                return;
            end
        end
        check_eq(tag, 32'(o_busy), 32'h0);
    endtask

    initial begin
        int starts;
        // Reset held 3 cycles with all requesters asserted
        i_reset_n  = 1'b0;
        i_req      = 4'b1111;
        i_req_data = {CHAR_D, CHAR_C, CHAR_B, CHAR_A};
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst_outputs", 32'({o_grant, o_start_uart, o_uart_data, o_busy, o_timeout}), 32'h0);
        end
        exp_q.push_back('{grant: 4'b0001, data: CHAR_A});
        i_reset_n = 1'b1;
        wait_start("rst_first_start");
        i_req = 4'b0000;
        wait_idle("rst_idle");

        // Single transfer: requester 2, busy from T+3 to T+20
        do_reset();
        busy_delay = 2;
        busy_len   = 17;
        i_req_data = {8'h99, CHAR_P, 8'h77, 8'h66};
        i_req      = 4'b0100;
        exp_q.push_back('{grant: 4'b0100, data: CHAR_P});
        tick();
        check_eq("single_start", 32'(o_start_uart), 32'h1);
        i_req = 4'b0000;
        for (int k = 2; k <= 21; k++) begin
            tick();
            check_eq($sformatf("single_busy_T%0d", k), 32'(o_busy), (k < 21) ? 32'h1 : 32'h0);
            check_eq($sformatf("single_data_T%0d", k), 32'(o_uart_data), 32'(CHAR_P));
        end
        check_eq("single_drained", 32'(exp_q.size()), 32'h0);

        // Round robin with all requesters held
        do_reset();
        busy_delay = 2;
        busy_len   = 5;
        i_req_data = {CHAR_D, CHAR_C, CHAR_B, CHAR_A};
        i_req      = 4'b1111;
        exp_q.push_back('{grant: 4'b0001, data: CHAR_A});
        exp_q.push_back('{grant: 4'b0010, data: CHAR_B});
        exp_q.push_back('{grant: 4'b0100, data: CHAR_C});
        exp_q.push_back('{grant: 4'b1000, data: CHAR_D});
        exp_q.push_back('{grant: 4'b0001, data: CHAR_A});
        starts = 0;
        for (int c = 0; c < 400 && starts < 5; c++) begin
            tick();
            if (o_start_uart === 1'b1) starts++;
        end
        check_eq("rr_start_count", 32'(starts), 32'd5);
        i_req = 4'b0000;
        wait_idle("rr_idle");

        // Timeout: transmitter never goes busy after granting requester 1
        do_reset();
        tx_mute    = 1'b1;
        i_req_data = {8'h33, 8'h22, 8'h5A, 8'h11};
        i_req      = 4'b0010;
        exp_q.push_back('{grant: 4'b0010, data: 8'h5A});
        tick();
        check_eq("to_start", 32'(o_start_uart), 32'h1);
        i_req = 4'b0000;
        for (int k = 1; k <= 18; k++) begin
            tick();
            check_eq($sformatf("to_pulse_S%0d", k), 32'(o_timeout), (k == 17) ? 32'h1 : 32'h0);
            if (k == 17) check_eq("to_busy_cleared", 32'(o_busy), 32'h0);
        end
        tx_mute = 1'b0;
        i_req   = 4'b1000;
        exp_q.push_back('{grant: 4'b1000, data: 8'h33});
        wait_start("to_next_start");
        i_req = 4'b0000;
        wait_idle("to_next_idle");

        // Late request arriving during WAIT_DONE of requester 0
        do_reset();
        busy_delay = 2;
        busy_len   = 8;
        i_req_data = {8'h44, 8'h22, 8'h33, 8'h11};
        i_req      = 4'b0001;
        exp_q.push_back('{grant: 4'b0001, data: 8'h11});
        wait_start("late_first_start");
        i_req = 4'b0000;
        for (int c = 0; c < 20 && i_uart_busy !== 1'b1; c++) tick();
        tick();
        tick();
        i_req = 4'b0100;
        exp_q.push_back('{grant: 4'b0100, data: 8'h22});
        for (int c = 0; c < 100 && o_busy === 1'b1; c++) begin
            check_eq("late_no_start_while_busy", 32'(o_start_uart), 32'h0);
            tick();
        end
        check_eq("late_idle_entry", 32'(o_busy), 32'h0);
        tick();
        check_eq("late_start_after_idle", 32'(o_start_uart), 32'h1);
        i_req = 4'b0000;
        wait_idle("late_idle");

        // Reset in the middle of WAIT_DONE
        do_reset();
        busy_delay = 2;
        busy_len   = 30;
        i_req_data = {CHAR_D, CHAR_C, 8'h77, CHAR_A};
        i_req      = 4'b0010;
        exp_q.push_back('{grant: 4'b0010, data: 8'h77});
        wait_start("mid_first_start");
        i_req = 4'b0000;
        for (int c = 0; c < 20 && i_uart_busy !== 1'b1; c++) tick();
        tick();
        tick();
        check_eq("mid_busy_before_reset", 32'(o_busy), 32'h1);
        i_reset_n = 1'b0;
        tick();
        check_eq("mid_busy", 32'(o_busy), 32'h0);
        check_eq("mid_data", 32'(o_uart_data), 32'h0);
        check_eq("mid_grant", 32'(o_grant), 32'h0);
        i_reset_n = 1'b1;
        i_req     = 4'b1111;
        exp_q.push_back('{grant: 4'b0001, data: CHAR_A});
        wait_start("mid_restart");
        i_req = 4'b0000;
        wait_idle("mid_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
